// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit:
// access-size and FSM state encodings, default timeout, alignment helpers.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int TIMEOUT_DEFAULT = 255;

  // Size code 2'b11 behaves exactly like a word access.
  function automatic size_e norm_size(input logic [1:0] s);
    return (s == 2'b11) ? SZ_WORD : size_e'(s);
  endfunction

  // Bytes are always aligned; halves need addr[0]=0; words need addr[1:0]=0.
  function automatic logic is_misaligned(input size_e s, input logic [1:0] off);
    case (s)
      SZ_HALF: return off[0];
      SZ_WORD: return (off != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the access unit and memory.
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering: byte enables and replicated write data for stores,
// lane extraction plus sign/zero extension for loads. Purely combinational.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  input  logic [31:0] store_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Select lanes by size and offset; extension bit is the lane MSB unless unsigned.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = store_i;
    ldata_o = rdata_i;
    lane_b  = rdata_i[{off_i, 3'b000} +: 8];
    lane_h  = rdata_i[{off_i[1], 4'b0000} +: 16];
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{store_i[7:0]}};
        ldata_o = {{24{~unsigned_i & lane_b[7]}}, lane_b};
      end
      SZ_HALF: begin
        be_o    = off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{store_i[15:0]}};
        ldata_o = {{16{~unsigned_i & lane_h[15]}}, lane_h};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns the latched ALU result into one
// request/ack transaction, stalls the pipeline meanwhile and returns
// aligned, extended load data to write-back.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               alu_res_m,
  input  logic [31:0]               store_data_m,
  input  logic                      mem_read_m,
  input  logic                      mem_write_m,
  input  logic [1:0]                mem_size_m,
  input  logic                      mem_unsigned_m,
  mem_access_unit_if.master         bus,
  output logic                      stall_m,
  output logic [31:0]               load_data_w,
  output logic                      load_valid,
  output logic                      misalign_err,
  output logic                      timeout_err
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [3:0]  bus_be_q;
  size_e       size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [31:0] load_data_q;
  logic        load_valid_q;
  logic        misalign_q;
  logic        timeout_q;

  logic        acc;
  size_e       size_in;
  logic        mis;
  logic        start;
  logic        busy;
  size_e       la_size;
  logic [1:0]  la_off;
  logic        la_uns;
  logic [3:0]  la_be;
  logic [31:0] la_wdata;
  logic [31:0] la_ldata;

  assign acc     = mem_read_m | mem_write_m;
  assign size_in = norm_size(mem_size_m);
  assign mis     = is_misaligned(size_in, alu_res_m[1:0]);
  assign start   = acc & ~mis;
  assign busy    = (state_q == BUSY);

  // The single aligner serves stores while idle and load extraction while busy.
  assign la_size = busy ? size_q : size_in;
  assign la_off  = busy ? off_q  : alu_res_m[1:0];
  assign la_uns  = busy ? uns_q  : mem_unsigned_m;

  mem_lane_align u_align (
    .size_i     (la_size),
    .off_i      (la_off),
    .unsigned_i (la_uns),
    .store_i    (store_data_m),
    .rdata_i    (bus.bus_rdata),
    .be_o       (la_be),
    .wdata_o    (la_wdata),
    .ldata_o    (la_ldata)
  );

  // Stall from the cycle the access is seen until the bus answers; never during reset.
  assign stall_m = ~reset & (((state_q == IDLE) & start) | busy);

  // Access FSM with registered bus outputs and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_be_q     <= '0;
      size_q       <= SZ_BYTE;
      uns_q        <= 1'b0;
      off_q        <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      timeout_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (acc && mis) begin
            misalign_q <= 1'b1;
          end else if (start) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= mem_write_m;
            bus_addr_q  <= {alu_res_m[31:2], 2'b00};
            bus_wdata_q <= la_wdata;
            bus_be_q    <= la_be;
            size_q      <= size_in;
            uns_q       <= mem_unsigned_m;
            off_q       <= alu_res_m[1:0];
            cnt_q       <= '0;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (bus.bus_ack) begin
            bus_req_q <= 1'b0;
            if (!bus_we_q) begin
              load_data_q  <= la_ldata;
              load_valid_q <= 1'b1;
            end
            state_q <= DONE;
          end else if (cnt_q == TO_LAST) begin
            bus_req_q   <= 1'b0;
            timeout_q   <= 1'b1;
            load_data_q <= '0;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: begin
          bus_req_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.bus_be    = bus_be_q;
  assign load_data_w   = load_data_q;
  assign load_valid    = load_valid_q;
  assign misalign_err  = misalign_q;
  assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random
// loads/stores against an arithmetic reference model of lanes and timing.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_res_m, store_data_m;
  logic        mem_read_m, mem_write_m, mem_unsigned_m;
  logic [1:0]  mem_size_m;
  logic        stall_m, load_valid, misalign_err, timeout_err;
  logic [31:0] load_data_w;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_ld = 32'h0;

  mem_access_unit_if bus_if ();

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .alu_res_m     (alu_res_m),
    .store_data_m  (store_data_m),
    .mem_read_m    (mem_read_m),
    .mem_write_m   (mem_write_m),
    .mem_size_m    (mem_size_m),
    .mem_unsigned_m(mem_unsigned_m),
    .bus           (bus_if),
    .stall_m       (stall_m),
    .load_data_w   (load_data_w),
    .load_valid    (load_valid),
    .misalign_err  (misalign_err),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input int k);
    int n = nbytes(sz);
    int mask = (1 << n) - 1;
    return 4'(mask << (k - (k % n)));
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] d);
    if (nbytes(sz) == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (nbytes(sz) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_ld(input logic [1:0] sz, input int k,
                                       input logic uns, input logic [31:0] r);
    int n = nbytes(sz);
    longint v, top;
    if (n == 4) return r;
    top = longint'(1) << (8 * n);
    v = (longint'(r) >> (8 * (k - (k % n)))) % top;
    if (!uns && v >= top / 2) v = v - top;
    return 32'(v);
  endfunction

  task automatic drop_inputs();
    mem_read_m = 0; mem_write_m = 0; alu_res_m = 0; store_data_m = 0;
    mem_size_m = 0; mem_unsigned_m = 0;
  endtask

  // Drive one MEM-stage instruction and check every cycle until the unit is idle again.
  // ack_after = BUSY cycles that pass before the ack cycle; negative = never ack.
  task automatic access(input string nm, input logic [31:0] addr, input logic [31:0] sd,
                        input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input int ack_after, input logic [31:0] rdata);
    int k = int'(addr[1:0]);
    int n = nbytes(sz);
    logic mis = (k % n) != 0;
    logic acked = 1'b0;
    logic is_load = rd & ~wr;
    @(negedge clk);
    alu_res_m = addr; store_data_m = sd; mem_read_m = rd; mem_write_m = wr;
    mem_size_m = sz; mem_unsigned_m = uns; bus_if.bus_ack = 0; bus_if.bus_rdata = $urandom;
    #1;
    checks++; if (stall_m !== !mis) begin errors++; $display("FAIL %s seen_stall got %0b want %0b", nm, stall_m, !mis); end
    checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL %s seen_req got %0b want 0", nm, bus_if.bus_req); end
    if (mis) begin
      @(negedge clk); drop_inputs(); #1;
      checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL %s misalign got %0b want 1", nm, misalign_err); end
      checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL %s mis_req got %0b want 0", nm, bus_if.bus_req); end
      checks++; if (load_data_w !== exp_ld) begin errors++; $display("FAIL %s mis_ld got %h want %h", nm, load_data_w, exp_ld); end
      @(negedge clk); #1;
      checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL %s misalign_pulse got %0b want 0", nm, misalign_err); end
      return;
    end
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      bus_if.bus_ack = (ack_after >= 0) && (c == ack_after + 1);
      bus_if.bus_rdata = bus_if.bus_ack ? rdata : $urandom;
      #1;
      checks++; if (bus_if.bus_req !== 1'b1) begin errors++; $display("FAIL %s busy_req c%0d got %0b want 1", nm, c, bus_if.bus_req); end
      checks++; if (stall_m !== 1'b1) begin errors++; $display("FAIL %s busy_stall c%0d got %0b want 1", nm, c, stall_m); end
      if (c == 1) begin
        checks++; if (bus_if.bus_addr !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL %s addr got %h want %h", nm, bus_if.bus_addr, {addr[31:2], 2'b00}); end
        checks++; if (bus_if.bus_be !== m_be(sz, k)) begin errors++; $display("FAIL %s be got %b want %b", nm, bus_if.bus_be, m_be(sz, k)); end
        checks++; if (bus_if.bus_we !== wr) begin errors++; $display("FAIL %s we got %0b want %0b", nm, bus_if.bus_we, wr); end
        if (wr) begin
          checks++; if (bus_if.bus_wdata !== m_wd(sz, sd)) begin errors++; $display("FAIL %s wdata got %h want %h", nm, bus_if.bus_wdata, m_wd(sz, sd)); end
        end
      end
      if (bus_if.bus_ack) begin acked = 1'b1; break; end
    end
    if (acked && is_load) exp_ld = m_ld(sz, k, uns, rdata);
    if (!acked) exp_ld = 32'h0;
    @(negedge clk);
    bus_if.bus_ack = 0; drop_inputs(); #1;
    checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL %s done_req got %0b want 0", nm, bus_if.bus_req); end
    checks++; if (stall_m !== 1'b0) begin errors++; $display("FAIL %s done_stall got %0b want 0", nm, stall_m); end
    checks++; if (load_valid !== (acked & is_load)) begin errors++; $display("FAIL %s load_valid got %0b want %0b", nm, load_valid, acked & is_load); end
    checks++; if (timeout_err !== !acked) begin errors++; $display("FAIL %s timeout_err got %0b want %0b", nm, timeout_err, !acked); end
    checks++; if (load_data_w !== exp_ld) begin errors++; $display("FAIL %s load_data got %h want %h", nm, load_data_w, exp_ld); end
    @(negedge clk); #1;
    checks++; if ((load_valid | timeout_err) !== 1'b0) begin errors++; $display("FAIL %s pulse_end got %0b/%0b want 0/0", nm, load_valid, timeout_err); end
    checks++; if (load_data_w !== exp_ld) begin errors++; $display("FAIL %s hold_ld got %h want %h", nm, load_data_w, exp_ld); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1; drop_inputs(); bus_if.bus_ack = 0; bus_if.bus_rdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 0; #1;
    checks++; if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_be} !== 6'b0) begin errors++; $display("FAIL reset_ctl got %b want 0", {bus_if.bus_req, bus_if.bus_we, bus_if.bus_be}); end
    checks++; if ({bus_if.bus_addr, bus_if.bus_wdata, load_data_w} !== 96'b0) begin errors++; $display("FAIL reset_data got %h want 0", {bus_if.bus_addr, bus_if.bus_wdata, load_data_w}); end
    checks++; if ({stall_m, load_valid, misalign_err, timeout_err} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0", {stall_m, load_valid, misalign_err, timeout_err}); end
  endtask

  task automatic test_word_load();
    access("word_load", 32'h0000_0010, 32'h0, 1, 0, 2'd2, 0, 2, 32'hDEAD_BEEF);
  endtask

  task automatic test_byte_load();
    access("byte_signed", 32'h0000_0013, 32'h0, 1, 0, 2'd0, 0, 0, 32'h80AA_BBCC);
    access("byte_unsigned", 32'h0000_0013, 32'h0, 1, 0, 2'd0, 1, 1, 32'h80AA_BBCC);
  endtask

  task automatic test_half_store();
    access("half_store", 32'h0000_0006, 32'h1234_ABCD, 0, 1, 2'd1, 0, 0, 32'h0);
    access("rd_and_wr", 32'h0000_0008, 32'h5566_7788, 1, 1, 2'd3, 0, 1, 32'hFFFF_FFFF);
  endtask

  task automatic test_misaligned();
    access("word_misalign", 32'h0000_0005, 32'h0, 1, 0, 2'd2, 0, 0, 32'h0);
    access("half_misalign", 32'h0000_0003, 32'hAAAA, 0, 1, 2'd1, 0, 0, 32'h0);
  endtask

  task automatic test_timeout();
    access("timeout", 32'h0000_0040, 32'h0, 1, 0, 2'd2, 0, -1, 32'h0);
    access("last_cycle_ack", 32'h0000_0042, 32'h0, 1, 0, 2'd1, 0, TO - 1, 32'h9876_5432);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    alu_res_m = 32'h20; mem_read_m = 1; mem_size_m = 2'd2; bus_if.bus_ack = 0;
    @(negedge clk); #1;
    checks++; if (bus_if.bus_req !== 1'b1) begin errors++; $display("FAIL rst_mid busy1_req got %0b want 1", bus_if.bus_req); end
    @(negedge clk); reset = 1; #1;
    checks++; if (stall_m !== 1'b0) begin errors++; $display("FAIL rst_mid rst_stall got %0b want 0", stall_m); end
    @(negedge clk); bus_if.bus_ack = 1; bus_if.bus_rdata = 32'h1234_5678; #1;
    checks++; if ({bus_if.bus_req, stall_m, load_valid, timeout_err, misalign_err} !== 5'b0) begin errors++; $display("FAIL rst_mid flags got %b want 0", {bus_if.bus_req, stall_m, load_valid, timeout_err, misalign_err}); end
    checks++; if ({bus_if.bus_addr, bus_if.bus_be, load_data_w} !== 68'b0) begin errors++; $display("FAIL rst_mid regs got %h want 0", {bus_if.bus_addr, bus_if.bus_be, load_data_w}); end
    @(negedge clk); reset = 0; drop_inputs(); #1;
    @(negedge clk); bus_if.bus_ack = 0; #1;
    checks++; if ({bus_if.bus_req, stall_m, load_valid} !== 3'b0) begin errors++; $display("FAIL rst_mid ack_ignored got %b want 0", {bus_if.bus_req, stall_m, load_valid}); end
    checks++; if (load_data_w !== 32'h0) begin errors++; $display("FAIL rst_mid ld got %h want 0", load_data_w); end
    exp_ld = 32'h0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int rw = $urandom_range(1, 3);
      access("random", $urandom, $urandom, rw[0], rw[1], 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_timeout();
    test_random();
    test_reset_mid();
    test_word_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
